// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encodings, default widths and a constant clog2 for the cache slice.
package cache_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WTHRU  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: one way of valid/tag/data storage with tag compare and a single write port.
module cache_way_array #(
    parameter int SETS   = 128,
    parameter int IDX_W  = 7,
    parameter int TAG_W  = 23,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_inv,
    input  logic              i_fill,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_valid,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [DATA_W-1:0] r_data [SETS];

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_valid <= '0;
        else if (i_inv) r_valid <= '0;
        else if (i_fill) r_valid[i_idx] <= 1'b1;

    // Tag and data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk)
        if (i_fill) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_data;
        end else if (i_wr) r_data[i_idx] <= i_wdata;

    assign o_valid = r_valid[i_idx];
    assign o_hit   = o_valid && (r_tag[i_idx] == i_tag);
    assign o_data  = r_data[i_idx];
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way write-through, read-allocate cache with refill handshake and round-robin replacement.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETS   = 128,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              Hit,
    input  logic              inv_all,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int IDX   = clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX - 2;
    localparam int RR_W  = (WAYS > 1) ? clog2(WAYS) : 1;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_resp;
    logic [RR_W-1:0]   r_rr [SETS];

    logic [IDX-1:0]    w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WAYS-1:0]   w_hit_v, w_valid_v;
    logic [DATA_W-1:0] w_data_v [WAYS];
    logic [DATA_W-1:0] w_hit_data;
    logic [RR_W-1:0]   w_victim, w_rr_next;
    logic              w_use_rr, w_fill, w_wr, w_inv;

    assign w_idx  = cpu_addr[IDX+1:2];
    assign w_tag  = cpu_addr[ADDR_W-1:IDX+2];
    assign Hit    = |w_hit_v;
    assign w_fill = (r_state == S_REFILL) && mem_ack;
    assign w_wr   = (r_state == S_IDLE) && cpu_req && cpu_we;
    assign w_inv  = (r_state == S_IDLE) && inv_all && !cpu_req;

    always_comb begin
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++) w_hit_data = w_hit_data | (w_hit_v[w] ? w_data_v[w] : '0);
    end

    // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_idx];
        w_use_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!w_valid_v[w]) begin
                w_victim = RR_W'(w);
                w_use_rr = 1'b0;
            end
    end

    assign w_rr_next = (r_rr[w_idx] == RR_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way_array #(.SETS(SETS), .IDX_W(IDX), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
            .clk         (clk),
            .rst         (rst),
            .i_idx       (w_idx),
            .i_tag       (w_tag),
            .i_inv       (w_inv),
            .i_fill      (w_fill && (w_victim == RR_W'(g))),
            .i_wr        (w_wr && w_hit_v[g]),
            .i_fill_data (mem_rdata),
            .i_wdata     (cpu_wdata),
            .o_valid     (w_valid_v[g]),
            .o_hit       (w_hit_v[g]),
            .o_data      (w_data_v[g])
        );
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= S_IDLE;
            r_resp  <= '0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (cpu_req) r_state <= cpu_we ? S_WTHRU : (Hit ? S_IDLE : S_REFILL);
                S_REFILL: if (mem_ack) begin
                    r_state <= S_RESP;
                    r_resp  <= mem_rdata;
                end
                S_WTHRU:  if (mem_ack) r_state <= S_RESP;
                default:  r_state <= S_IDLE;
            endcase
            if (w_fill && w_use_rr) r_rr[w_idx] <= w_rr_next;
        end

    assign cpu_ready = ((r_state == S_IDLE) && cpu_req && !cpu_we && Hit) || (r_state == S_RESP);
    assign cpu_rdata = (r_state == S_RESP) ? r_resp : w_hit_data;
    assign mem_req   = (r_state == S_REFILL) || (r_state == S_WTHRU);
    assign mem_we    = (r_state == S_WTHRU);
    assign mem_addr  = cpu_addr & ~ADDR_W'(3);
    assign mem_wdata = cpu_wdata;
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed checks of hits, refills, eviction, write-through, invalidate and reset abort.
module tb_set_assoc_cache;
    logic        clk = 0, rst = 0;
    logic        cpu_req = 0, cpu_we = 0, inv_all = 0, mem_ack = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, mem_rdata = 0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        cpu_ready, Hit, mem_req, mem_we;
    int          n_tests = 0, n_fail = 0;

    logic [31:0] t_rdata, t_maddr, t_mwd;
    logic        t_mwe, t_used, t_hit0, t_stable;
    int          t_lat, t_nreq;

    set_assoc_cache dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .Hit(Hit),
        .inv_all(inv_all), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU access; the bench plays memory, acking after dly cycles of mem_req.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] md, input int dly);
        @(negedge clk);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        #1;
        t_hit0 = Hit; t_used = 0; t_stable = 1; t_nreq = 0; t_lat = 0;
        t_maddr = 0; t_mwe = 0; t_mwd = 0;
        while (!cpu_ready && t_lat < 100) begin
            if (mem_req) begin
                if (!t_used) begin
                    t_used = 1; t_maddr = mem_addr; t_mwe = mem_we; t_mwd = mem_wdata;
                end
                if (mem_addr !== t_maddr) t_stable = 0;
                mem_rdata = md;
                mem_ack = (t_nreq == dly);
                t_nreq++;
            end
            @(negedge clk); #1;
            mem_ack = 0;
            t_lat++;
        end
        chk("ready_reached", 32'(cpu_ready), 1);
        t_rdata = cpu_rdata;
        cpu_req = 0;
        @(negedge clk); #1;
        chk("ready_once", 32'(cpu_ready), 0);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        cpu_addr = 32'h100; #1;
        chk("rst_ready", 32'(cpu_ready), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_hit", 32'(Hit), 0);
        @(negedge clk); rst = 1;

        access(0, 32'h100, 0, 32'hDEAD_BEEF, 0);
        chk("t1_miss_mem", 32'(t_used), 1);
        chk("t1_miss_addr", t_maddr, 32'h100);
        chk("t1_miss_we", 32'(t_mwe), 0);
        chk("t1_miss_lat", t_lat, 2);
        chk("t1_miss_data", t_rdata, 32'hDEAD_BEEF);
        access(0, 32'h100, 0, 32'h0, 0);
        chk("t1_hit", 32'(t_hit0), 1);
        chk("t1_hit_lat", t_lat, 0);
        chk("t1_hit_nomem", 32'(t_used), 0);
        chk("t1_hit_data", t_rdata, 32'hDEAD_BEEF);

        access(0, 32'h000, 0, 32'hA000_0000, 0);
        access(0, 32'h200, 0, 32'hA000_0200, 0);
        chk("t2_fill2_data", t_rdata, 32'hA000_0200);
        access(0, 32'h400, 0, 32'hA000_0400, 0);
        chk("t2_evict_miss", 32'(t_used), 1);
        access(0, 32'h000, 0, 32'hB000_0000, 0);
        chk("t2_reload_miss", 32'(t_used), 1);
        chk("t2_reload_data", t_rdata, 32'hB000_0000);
        access(0, 32'h400, 0, 32'h0, 0);
        chk("t2_keep_hit", 32'(t_hit0), 1);
        chk("t2_keep_nomem", 32'(t_used), 0);
        chk("t2_keep_data", t_rdata, 32'hA000_0400);

        access(1, 32'h100, 32'h1234_5678, 0, 0);
        chk("t3_st_hit", 32'(t_hit0), 1);
        chk("t3_st_mem", 32'(t_used), 1);
        chk("t3_st_we", 32'(t_mwe), 1);
        chk("t3_st_addr", t_maddr, 32'h100);
        chk("t3_st_wdata", t_mwd, 32'h1234_5678);
        chk("t3_st_lat", t_lat, 2);
        access(0, 32'h100, 0, 0, 0);
        chk("t3_ld_hit", 32'(t_used), 0);
        chk("t3_ld_data", t_rdata, 32'h1234_5678);
        access(1, 32'h802, 32'hCAFE_0800, 0, 0);
        chk("t3_stm_hit", 32'(t_hit0), 0);
        chk("t3_stm_addr", t_maddr, 32'h800);
        chk("t3_stm_wdata", t_mwd, 32'hCAFE_0800);
        access(0, 32'h800, 0, 32'h55AA_0800, 0);
        chk("t3_noalloc_miss", 32'(t_used), 1);
        chk("t3_noalloc_data", t_rdata, 32'h55AA_0800);

        @(negedge clk); inv_all = 1;
        @(negedge clk); inv_all = 0;
        access(0, 32'h100, 0, 32'h1111_1111, 0);
        chk("t4_inv_miss", 32'(t_used), 1);
        chk("t4_inv_data", t_rdata, 32'h1111_1111);
        access(0, 32'h000, 0, 32'h2222_2222, 0);
        chk("t4_inv_miss2", 32'(t_used), 1);

        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200; #1;
        k = 0;
        while (!mem_req && k < 10) begin @(negedge clk); #1; k++; end
        chk("t5_in_refill", 32'(mem_req), 1);
        rst = 0; #1;
        chk("t5_mem_req", 32'(mem_req), 0);
        chk("t5_ready", 32'(cpu_ready), 0);
        chk("t5_hit", 32'(Hit), 0);
        cpu_req = 0;
        @(negedge clk); rst = 1;
        access(0, 32'h100, 0, 32'h3333_3333, 0);
        chk("t5_lost_line", 32'(t_used), 1);
        chk("t5_data", t_rdata, 32'h3333_3333);

        access(0, 32'h600, 0, 32'h6666_0600, 5);
        chk("t6_lat", t_lat, 7);
        chk("t6_req_cycles", t_nreq, 6);
        chk("t6_addr_stable", 32'(t_stable), 1);
        chk("t6_addr", t_maddr, 32'h600);
        chk("t6_data", t_rdata, 32'h6666_0600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
